frequency_division_scheduler: RTL
=================================

# frequency_division_scheduler

Shares one programmable odd/even frequency divider between four requesters. Each requester asks for a divisor. The block grants requests round-robin, runs the divider for a fixed burst of output periods at the granted divisor, then signals completion. It sits between the system-level clients and the divided-clock flag that downstream logic consumes.

## Interface
- DIVISOR_WIDTH, 8, width of each requested divisor.
- BURST_PERIODS, 4, number of full divided periods produced per grant (≥1).
- system_clock  input  1  single clock; all logic on rising edge.
- system_reset_n  input  1  asynchronous, active-low reset.
- request_valid  input  4  bit i high = requester i wants the divider; held until its request_done bit pulses.
- request_divisor  input  4*DIVISOR_WIDTH  divisor of requester i in bits [i*W +: W]; sampled only at grant.
- division_clock_flag  output  1  divided clock flag (registered).
- busy  output  1  high while a burst runs.
- active_id  output  2  index of requester owning the divider; valid while busy.
- request_done  output  4  one-cycle pulse on bit i when requester i's request completes.
- request_error  output  1  one-cycle pulse, coincident with request_done, when the divisor was rejected.

## Operation
- States: IDLE, RUN.
- Round-robin pointer `next_id` (2 bits, reset 0): the search starts at next_id and wraps 3→0.
- IDLE:
  - If no request_valid bit is set, stay in IDLE.
  - Otherwise take the first set bit at or after next_id → winner w.
  - Latch divisor D = request_divisor[w]. Set next_id = w+1 mod 4.
  - If D < 2: pulse request_done[w] and request_error on the next cycle, then stay in IDLE.
  - Otherwise go to RUN with active_id = w, busy = 1, phase counter = 0, period counter = 0.
- RUN:
  - The phase counter counts 0..D-1 and wraps.
  - division_clock_flag = 1 while phase < ceil(D/2), else 0. High time is (D+1)/2 cycles and low time is D/2 cycles, using integer division on DIVISOR_WIDTH+1 bits so that D = 2^W−1 does not overflow.
  - The period counter increments when phase = D-1.
  - When phase = D-1 and period = BURST_PERIODS-1:
    - next cycle: go to IDLE, busy = 0, flag = 0;
    - pulse request_done[active_id].
- Deasserting request_valid during RUN is ignored. The burst completes and done still pulses.
- Changing request_divisor during RUN has no effect.
- Only one request_done bit is ever high in a cycle.
- Asynchronous reset (any time, including mid-burst):
  - state = IDLE, next_id = 0;
  - flag, busy, active_id, request_done and request_error all = 0;
  - counters cleared;
  - no done pulse is issued for the aborted burst.

## Timing
- Grant latency: with request_valid set and the block in IDLE at edge k, busy = 1 and the first flag-high cycle start after edge k+1.
- Burst length: exactly D × BURST_PERIODS cycles with busy = 1.
- request_done is high in the first cycle after the burst, i.e. the cycle in which busy has returned to 0.
- Back-to-back grants: after a burst the block spends at least one IDLE cycle (the arbitration cycle) before the next burst. The earliest next flag-high is therefore 2 cycles after the last cycle of the previous burst.
- Rejected divisor: request_done/request_error pulse one cycle after the IDLE arbitration cycle. busy never rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then a single request with request_valid = 0001 and D = 5 → busy rises one cycle after grant. The flag pattern is 11100 repeated 4 times (20 busy cycles). request_done = 0001 pulses once; request_error = 0.
- Even divisor, requester 2 with D = 4 → flag pattern 1100 ×4 (16 cycles); active_id = 2 throughout; done = 0100.
- Round-robin fairness: all four valid with D = 3, re-asserted after each done → grants in order 0, 1, 2, 3, 0. Each burst is 12 cycles with one IDLE cycle between bursts.
- Rejected divisor: requester 1 with D = 1 → request_done = 0010 and request_error pulse together; busy stays 0; next_id advances to 2.
- Reset mid-burst: assert system_reset_n = 0 at phase 2 of period 1 with D = 7 → all outputs 0 immediately, no done pulse. After release with request 3 pending, requester 3 is granted, searching from pointer 0.
- Mid-burst input changes: alter request_divisor and drop request_valid during RUN → the burst keeps the original D and completes; done still pulses.

Source files
------------

// File: rtl/frequency_division_scheduler_if.sv
// frequency_division_scheduler_if: request/grant bundle between four clients and the shared divider.
// Ports (slave = scheduler side):
//   request_valid       clients -> scheduler  4             one bit per requester, held until its done pulse
//   request_divisor     clients -> scheduler  4*DIVISOR_WIDTH  divisor of requester i in [i*W +: W]
//   division_clock_flag scheduler -> clients  1             divided clock flag
//   busy                scheduler -> clients  1             burst in progress
//   active_id           scheduler -> clients  2             owner of the divider while busy
//   request_done        scheduler -> clients  4             one-cycle completion pulse per requester
//   request_error       scheduler -> clients  1             pulses with request_done when the divisor was rejected
interface frequency_division_scheduler_if #(
    parameter int DIVISOR_WIDTH = 8
);
    logic [3:0]                 request_valid;
    logic [4*DIVISOR_WIDTH-1:0] request_divisor;
    logic                       division_clock_flag;
    logic                       busy;
    logic [1:0]                 active_id;
    logic [3:0]                 request_done;
    logic                       request_error;

    modport master (
        output request_valid, request_divisor,
        input  division_clock_flag, busy, active_id, request_done, request_error
    );

    modport slave (
        input  request_valid, request_divisor,
        output division_clock_flag, busy, active_id, request_done, request_error
    );
endinterface

// File: rtl/frequency_division_scheduler.sv
// frequency_division_scheduler: round-robin sharing of one odd/even clock divider among four requesters.
// Ports:
//   system_clock    single rising-edge clock
//   system_reset_n  asynchronous active-low reset
//   bus             frequency_division_scheduler_if.slave (requests in, flag/busy/done/error out)
// Each grant runs BURST_PERIODS full divided periods at the divisor latched at grant time.
module frequency_division_scheduler #(
    parameter int DIVISOR_WIDTH = 8,
    parameter int BURST_PERIODS = 4
) (
    input  logic                          system_clock,
    input  logic                          system_reset_n,
    frequency_division_scheduler_if.slave bus
);
    localparam int PW  = (BURST_PERIODS > 1) ? $clog2(BURST_PERIODS) : 1;
    localparam int DW1 = DIVISOR_WIDTH + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [1:0]               next_id;
    logic [1:0]               win;
    logic [DIVISOR_WIDTH-1:0] div;
    logic [DIVISOR_WIDTH-1:0] win_div;
    logic [DIVISOR_WIDTH-1:0] phase;
    logic [DIVISOR_WIDTH-1:0] phase_next;
    logic [DW1-1:0]           half;
    logic [PW-1:0]            period;
    logic                     phase_last;
    logic                     burst_last;

    // Descending scan so the requester closest to next_id is the last (winning) assignment.
    always_comb begin
        win = next_id;
        for (int i = 3; i >= 0; i--)
            if (bus.request_valid[next_id + 2'(i)]) win = next_id + 2'(i);
    end

    assign win_div    = bus.request_divisor[win*DIVISOR_WIDTH +: DIVISOR_WIDTH];
    // High time is ceil(D/2); one extra bit keeps D = 2^W-1 from overflowing.
    assign half       = ({1'b0, div} + DW1'(1)) >> 1;
    assign phase_last = phase == div - DIVISOR_WIDTH'(1);
    assign burst_last = phase_last && period == PW'(BURST_PERIODS - 1);
    assign phase_next = phase_last ? '0 : phase + DIVISOR_WIDTH'(1);

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state                   <= IDLE;
            next_id                 <= '0;
            div                     <= '0;
            phase                   <= '0;
            period                  <= '0;
            bus.division_clock_flag <= 1'b0;
            bus.busy                <= 1'b0;
            bus.active_id           <= '0;
            bus.request_done        <= '0;
            bus.request_error       <= 1'b0;
        end else begin
            bus.request_done  <= '0;
            bus.request_error <= 1'b0;
            if (state == IDLE) begin
                if (|bus.request_valid) begin
                    next_id <= win + 2'd1;
                    if (win_div < DIVISOR_WIDTH'(2)) begin
                        bus.request_done[win] <= 1'b1;
                        bus.request_error     <= 1'b1;
                    end else begin
                        state                   <= RUN;
                        div                     <= win_div;
                        phase                   <= '0;
                        period                  <= '0;
                        bus.active_id           <= win;
                        bus.busy                <= 1'b1;
                        bus.division_clock_flag <= 1'b1;
                    end
                end
            end else begin
                phase                   <= phase_next;
                // Flag is registered from the phase it will accompany next cycle.
                bus.division_clock_flag <= {1'b0, phase_next} < half;
                if (phase_last) period <= period + PW'(1);
                if (burst_last) begin
                    state                          <= IDLE;
                    bus.busy                       <= 1'b0;
                    bus.division_clock_flag        <= 1'b0;
                    bus.request_done[bus.active_id] <= 1'b1;
                end
            end
        end
    end
endmodule
